// File: rtl/regfile_pkg.sv
// Shared definitions for the regfile writeback path: default widths and grant encodings.
package regfile_pkg;

  localparam int DEF_REG_WIDTH      = 32;
  localparam int DEF_REG_DEPTH      = 32;
  localparam int DEF_REG_ADDR_WIDTH = 5;

  localparam logic LAST_ALU = 1'b0;
  localparam logic LAST_LSU = 1'b1;

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_ALU  = 2'b01,
    GNT_LSU  = 2'b10
  } gnt_e;

endpackage

// File: rtl/wb_starve_counter.sv
// Saturating count of cycles the ALU has been held off; at_max forces an ALU grant.
module wb_starve_counter
  import regfile_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

  logic [CW-1:0] wait_cnt;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == MAX_CNT) ? v : v + CW'(1);
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (clr) begin
      wait_cnt <= '0;
    end else if (inc) begin
      wait_cnt <= sat_inc(wait_cnt);
    end
  end

  assign at_max = (wait_cnt == MAX_CNT);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU and LSU writebacks onto the single regfile write port, one registered stage.
// Define WB_RR_EN for round-robin arbitration; otherwise LSU has priority with a starvation guard.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int REG_WIDTH      = DEF_REG_WIDTH,
  parameter int REG_DEPTH      = DEF_REG_DEPTH,
  parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
  parameter int MAX_WAIT       = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      alu_valid,
  input  logic [REG_ADDR_WIDTH-1:0] alu_addr,
  input  logic [REG_WIDTH-1:0]      alu_data,
  output logic                      alu_ready,
  input  logic                      lsu_valid,
  input  logic [REG_ADDR_WIDTH-1:0] lsu_addr,
  input  logic [REG_WIDTH-1:0]      lsu_data,
  output logic                      lsu_ready,
  output logic                      RegWEn,
  output logic [REG_ADDR_WIDTH-1:0] addrD,
  output logic [REG_WIDTH-1:0]      dataD,
  output logic [REG_DEPTH-1:0]      wb_busy_mask
);

  gnt_e                      gnt_p0;
  logic                      accept_p0;
  logic [REG_ADDR_WIDTH-1:0] addr_p0;
  logic [REG_WIDTH-1:0]      data_p0;
  logic                      last_grant;

  logic                      vld_p1;
  logic [REG_ADDR_WIDTH-1:0] addr_p1;
  logic [REG_WIDTH-1:0]      data_p1;
  logic [REG_DEPTH-1:0]      mask_p1;

  function automatic logic [REG_DEPTH-1:0] onehot(input logic [REG_ADDR_WIDTH-1:0] a);
    logic [REG_DEPTH-1:0] m;
    m    = '0;
    m[a] = 1'b1;
    return m;
  endfunction

`ifndef WB_RR_EN
  logic at_max;
  logic unused_last_grant;

  wb_starve_counter #(.MAX_WAIT(MAX_WAIT)) u_starve (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (alu_valid && !alu_ready),
    .clr     (!alu_valid || alu_ready),
    .at_max  (at_max)
  );

  // last_grant only steers arbitration in round-robin builds
  assign unused_last_grant = last_grant;
`endif

  // Stage p0: combinational grant and beat selection
  always_comb begin
    gnt_p0 = GNT_NONE;
    if (!reset_n) begin
      gnt_p0 = GNT_NONE;
    end else if (alu_valid && !lsu_valid) begin
      gnt_p0 = GNT_ALU;
    end else if (lsu_valid && !alu_valid) begin
      gnt_p0 = GNT_LSU;
    end else if (alu_valid && lsu_valid) begin
`ifdef WB_RR_EN
      gnt_p0 = (last_grant == LAST_LSU) ? GNT_ALU : GNT_LSU;
`else
      gnt_p0 = at_max ? GNT_ALU : GNT_LSU;
`endif
    end
  end

  assign alu_ready = (gnt_p0 == GNT_ALU);
  assign lsu_ready = (gnt_p0 == GNT_LSU);
  assign accept_p0 = (gnt_p0 != GNT_NONE);
  assign addr_p0   = (gnt_p0 == GNT_ALU) ? alu_addr : lsu_addr;
  assign data_p0   = (gnt_p0 == GNT_ALU) ? alu_data : lsu_data;

  // Stage p1: registered regfile write port; x0 beats are accepted but never write
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1     <= 1'b0;
      addr_p1    <= '0;
      data_p1    <= '0;
      mask_p1    <= '0;
      last_grant <= LAST_LSU;
    end else begin
      vld_p1  <= accept_p0 && (addr_p0 != '0);
      mask_p1 <= (accept_p0 && (addr_p0 != '0)) ? onehot(addr_p0) : '0;
      if (accept_p0) begin
        addr_p1    <= addr_p0;
        data_p1    <= data_p0;
        last_grant <= (gnt_p0 == GNT_ALU) ? LAST_ALU : LAST_LSU;
      end
    end
  end

  assign RegWEn       = vld_p1;
  assign addrD        = addr_p1;
  assign dataD        = data_p1;
  assign wb_busy_mask = mask_p1;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter; WB_RR_EN selects the round-robin scenario.
module tb_regfile_wb_arbiter;

  localparam int MAX_WAIT = 4;
  localparam int G_NONE = 0;
  localparam int G_ALU  = 1;
  localparam int G_LSU  = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        alu_valid, lsu_valid;
  logic [4:0]  alu_addr, lsu_addr;
  logic [31:0] alu_data, lsu_data;
  logic        alu_ready, lsu_ready;
  logic        RegWEn;
  logic [4:0]  addrD;
  logic [31:0] dataD;
  logic [31:0] wb_busy_mask;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] mask;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  logic [4:0]  m_addr;
  logic [31:0] m_data;
`ifdef WB_RR_EN
  logic        m_last;
`else
  int          m_wait;
`endif

  regfile_wb_arbiter #(
    .REG_WIDTH(32), .REG_DEPTH(32), .REG_ADDR_WIDTH(5), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_addr(lsu_addr), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .RegWEn(RegWEn), .addrD(addrD), .dataD(dataD), .wb_busy_mask(wb_busy_mask)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_addr = '0;
    m_data = '0;
`ifdef WB_RR_EN
    m_last = 1'b1;
`else
    m_wait = 0;
`endif
    sb.delete();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    alu_valid = 1'b0;
    lsu_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  // One clock: drive, check readys against the model, push expectation, pop after the edge.
  task automatic do_cycle(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                          input logic lv, input logic [4:0] la, input logic [31:0] ld,
                          output int obs);
    exp_t e, o;
    int g;
    @(negedge clk);
    alu_valid = av; alu_addr = aa; alu_data = ad;
    lsu_valid = lv; lsu_addr = la; lsu_data = ld;
    #1;
    g = G_NONE;
    if (av && !lv) g = G_ALU;
    else if (lv && !av) g = G_LSU;
    else if (av && lv) begin
`ifdef WB_RR_EN
      g = (m_last == 1'b1) ? G_ALU : G_LSU;
`else
      g = (m_wait == MAX_WAIT) ? G_ALU : G_LSU;
`endif
    end
    obs = alu_ready ? G_ALU : (lsu_ready ? G_LSU : G_NONE);
    checks++;
    if (alu_ready !== (g == G_ALU) || lsu_ready !== (g == G_LSU)) begin
      errors++;
      $display("FAIL ready: got alu=%b lsu=%b want alu=%b lsu=%b", alu_ready, lsu_ready,
               (g == G_ALU), (g == G_LSU));
    end
    if (g != G_NONE) begin
      m_addr = (g == G_ALU) ? aa : la;
      m_data = (g == G_ALU) ? ad : ld;
      e.we   = (m_addr != 5'd0);
      e.mask = (m_addr != 5'd0) ? (32'h1 << m_addr) : 32'h0;
    end else begin
      e.we   = 1'b0;
      e.mask = 32'h0;
    end
    e.addr = m_addr;
    e.data = m_data;
`ifdef WB_RR_EN
    if (g != G_NONE) m_last = (g == G_ALU) ? 1'b0 : 1'b1;
`else
    if (av && g != G_ALU) m_wait = (m_wait + 1 > MAX_WAIT) ? MAX_WAIT : m_wait + 1;
    else m_wait = 0;
`endif
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard: empty queue");
    end else begin
      o = sb.pop_front();
      checks++;
      if (RegWEn !== o.we) begin
        errors++; $display("FAIL RegWEn: got %b want %b", RegWEn, o.we);
      end
      checks++;
      if (addrD !== o.addr) begin
        errors++; $display("FAIL addrD: got %0d want %0d", addrD, o.addr);
      end
      checks++;
      if (dataD !== o.data) begin
        errors++; $display("FAIL dataD: got %h want %h", dataD, o.data);
      end
      checks++;
      if (wb_busy_mask !== o.mask) begin
        errors++; $display("FAIL wb_busy_mask: got %h want %h", wb_busy_mask, o.mask);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0;
    alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h11;
    lsu_valid = 1'b1; lsu_addr = 5'd4; lsu_data = 32'h22;
    #2;
    checks++;
    if (alu_ready !== 1'b0 || lsu_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got alu=%b lsu=%b want 0 0", alu_ready, lsu_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (RegWEn !== 1'b0 || wb_busy_mask !== 32'h0) begin
      errors++; $display("FAIL reset_out: got we=%b mask=%h want 0 0", RegWEn, wb_busy_mask);
    end
    checks++;
    if (addrD !== 5'd0 || dataD !== 32'h0) begin
      errors++; $display("FAIL reset_data: got addr=%0d data=%h want 0 0", addrD, dataD);
    end
    @(negedge clk);
    alu_valid = 1'b0;
    lsu_valid = 1'b0;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_single_alu();
    int obs;
    do_cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, obs);
    checks++;
    if (obs != G_ALU || RegWEn !== 1'b1 || addrD !== 5'd5 || dataD !== 32'hDEADBEEF ||
        wb_busy_mask !== 32'h20) begin
      errors++;
      $display("FAIL single_alu: got gnt=%0d we=%b addr=%0d data=%h mask=%h want 1 1 5 deadbeef 20",
               obs, RegWEn, addrD, dataD, wb_busy_mask);
    end
    do_cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, obs);
  endtask

  task automatic test_x0_squash();
    int obs;
    do_cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h1234, obs);
    checks++;
    if (obs != G_LSU || RegWEn !== 1'b0 || wb_busy_mask !== 32'h0) begin
      errors++;
      $display("FAIL x0_squash: got gnt=%0d we=%b mask=%h want 2 0 0", obs, RegWEn, wb_busy_mask);
    end
  endtask

  task automatic test_back_to_back();
    int obs;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) do_cycle(1'b1, 5'(10 + i), 32'hB000_0000 + i, 1'b0, 5'd0, 32'h0, obs);
      else            do_cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'(10 + i), 32'hC000_0000 + i, obs);
    end
  endtask

`ifndef WB_RR_EN
  task automatic test_starvation();
    int obs;
    int beat = 0;
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      do_cycle(1'b1, 5'd3, 32'hA000_0000 + beat, 1'b1, 5'd4, 32'h5000_0000 + i, obs);
      checks++;
      if (obs != ((i % 5 == 4) ? G_ALU : G_LSU) || addrD !== ((i % 5 == 4) ? 5'd3 : 5'd4)) begin
        errors++;
        $display("FAIL starvation[%0d]: got gnt=%0d addrD=%0d want gnt=%0d", i, obs, addrD,
                 (i % 5 == 4) ? G_ALU : G_LSU);
      end
      if (obs == G_ALU) beat++;
    end
  endtask
`else
  task automatic test_round_robin();
    int obs;
    int beat_a = 0;
    int beat_l = 0;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      do_cycle(1'b1, 5'd3, 32'hA000_0000 + beat_a, 1'b1, 5'd4, 32'h5000_0000 + beat_l, obs);
      checks++;
      if (obs != ((i % 2 == 0) ? G_ALU : G_LSU)) begin
        errors++;
        $display("FAIL round_robin[%0d]: got gnt=%0d want %0d", i, obs,
                 (i % 2 == 0) ? G_ALU : G_LSU);
      end
      if (obs == G_ALU) beat_a++;
      if (obs == G_LSU) beat_l++;
    end
  endtask
`endif

  task automatic test_same_addr_and_reset();
    int obs, obs2;
    apply_reset();
    do_cycle(1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2, obs);
`ifndef WB_RR_EN
    checks++;
    if (dataD !== 32'h2) begin
      errors++; $display("FAIL same_addr_first: got %h want 2", dataD);
    end
`endif
    if (obs == G_LSU) do_cycle(1'b1, 5'd7, 32'h1, 1'b0, 5'd0, 32'h0, obs2);
    else              do_cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h2, obs2);
`ifndef WB_RR_EN
    checks++;
    if (dataD !== 32'h1) begin
      errors++; $display("FAIL same_addr_final: got %h want 1", dataD);
    end
`endif
    do_cycle(1'b1, 5'd9, 32'hCAFE, 1'b0, 5'd0, 32'h0, obs);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (RegWEn !== 1'b0 || wb_busy_mask !== 32'h0 || dataD !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset: got we=%b mask=%h data=%h want 0 0 0", RegWEn, wb_busy_mask, dataD);
    end
    @(negedge clk);
    alu_valid = 1'b0;
    lsu_valid = 1'b0;
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    reset_n = 1'b0;
    alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_addr = '0; lsu_data = '0;
    model_reset();
    test_reset();
    test_single_alu();
    test_x0_squash();
    test_back_to_back();
`ifndef WB_RR_EN
    test_starvation();
`else
    test_round_robin();
`endif
    test_same_addr_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
